alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 24 ++
 rtl/alu_slt_cmp.sv | 22 ++
 rtl/alu_issue_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and data width for the ALU issue controller.
// Pure definitions: no latency or flow-control behaviour of its own.
package alu_issue_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SLT2 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic func_legal(input logic [2:0] f);
    return (f == OP_AND) || (f == OP_OR) || (f == OP_ADD) || (f == OP_SUB) || (f == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_slt_cmp.sv
// Less-than and subtract-overflow decode from a completed a-b ALU pass; purely combinational.
// No state and no flow control; the result is valid whenever the ALU inputs are.
module alu_slt_cmp
  import alu_issue_ctrl_pkg::*;
#(
  parameter bit SLT_SIGNED = 1'b1
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_carry,
  output logic              o_lt,
  output logic              o_ovf
);

  localparam int MSB = DATA_W - 1;

  assign o_ovf = (i_a[MSB] != i_b[MSB]) & (i_result[MSB] != i_a[MSB]);
  // Unsigned: a carry out of a + ~b + 1 means no borrow, so a >= b.
  assign o_lt  = SLT_SIGNED ? (i_result[MSB] ^ o_ovf) : ~i_carry;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to an external ALU; rsp 1 (illegal) / 2 / 3 (SLT) cycles after accept.
// Holds rsp_* until rsp_ready; req_ready only in IDLE. ALU_ISSUE_FLAGS_EN adds rsp_zero/rsp_ovf.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter bit SLT_SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_func,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_err,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic              rsp_zero,
  output logic              rsp_ovf,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_carry_in,
  output logic              alu_less,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out
);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_func;
  logic [DATA_W-1:0] r_a, r_b, r_result;
  logic              r_carry, r_err, r_lt;
  logic              w_accept, w_lt;

  assign w_accept   = req_valid & (r_state == ST_IDLE);
  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_result = r_result;
  assign rsp_carry  = r_carry;
  assign rsp_err    = r_err;

`ifdef ALU_ISSUE_FLAGS_EN
  logic w_ovf;
`else
  logic w_ovf_unused;
`endif

  alu_slt_cmp #(.SLT_SIGNED(SLT_SIGNED)) u_slt_cmp (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_result (alu_result),
    .i_carry  (alu_carry_out),
    .o_lt     (w_lt),
`ifdef ALU_ISSUE_FLAGS_EN
    .o_ovf    (w_ovf)
`else
    .o_ovf    (w_ovf_unused)
`endif
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = OP_AND;
    alu_carry_in = 1'b0;
    alu_less     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = func_legal(req_func) ? ST_EXEC : ST_RESP;
      end
      ST_EXEC: begin
        // SLT's first pass is a plain subtract; the compare is decoded from its result.
        alu_a        = r_a;
        alu_b        = r_b;
        alu_op       = (r_func == OP_SLT) ? OP_SUB : r_func;
        alu_carry_in = (r_func == OP_SUB) || (r_func == OP_SLT);
        w_state_nxt  = (r_func == OP_SLT) ? ST_SLT2 : ST_RESP;
      end
      ST_SLT2: begin
        alu_a       = r_a;
        alu_b       = r_b;
        alu_op      = OP_SLT;
        alu_less    = r_lt;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_func   <= OP_AND;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_err    <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_func <= req_func;
            r_a    <= req_a;
            r_b    <= req_b;
            if (!func_legal(req_func)) begin
              r_result <= '0;
              r_carry  <= 1'b0;
              r_err    <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (r_func == OP_SLT) begin
            r_lt <= w_lt;
          end else begin
            r_result <= alu_result;
            r_carry  <= alu_carry_out;
            r_err    <= 1'b0;
          end
        end
        ST_SLT2: begin
          r_result <= alu_result;
          r_carry  <= 1'b0;
          r_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic r_zero, r_ovf, w_add_ovf;

  assign w_add_ovf = (r_a[DATA_W-1] == r_b[DATA_W-1]) & (alu_result[DATA_W-1] != r_a[DATA_W-1]);
  assign rsp_zero  = r_zero;
  assign rsp_ovf   = r_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !func_legal(req_func)) begin
            r_zero <= 1'b1;
            r_ovf  <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (r_func != OP_SLT) begin
            r_zero <= (alu_result == '0);
            r_ovf  <= (r_func == OP_ADD) ? w_add_ovf : ((r_func == OP_SUB) ? w_ovf : 1'b0);
          end
        end
        ST_SLT2: begin
          r_zero <= (alu_result == '0);
          r_ovf  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench driving a signed and an unsigned instance in lockstep against a behavioural ALU,
// with per-request expectations queued at issue and popped at the response handshake.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [2:0]  req_func;
  logic [31:0] req_a, req_b;
  logic        rsp_ready;

  logic        req_ready    [2];
  logic        rsp_valid    [2];
  logic [31:0] rsp_result   [2];
  logic        rsp_carry    [2];
  logic        rsp_err      [2];
  logic [31:0] alu_a        [2];
  logic [31:0] alu_b        [2];
  logic [2:0]  alu_op       [2];
  logic        alu_carry_in [2];
  logic        alu_less     [2];
  logic [31:0] alu_result   [2];
  logic        alu_carry_out[2];
`ifdef ALU_ISSUE_FLAGS_EN
  logic        rsp_zero     [2];
  logic        rsp_ovf      [2];
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [33:0] e1;
    logic [33:0] e0;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Behavioural downstream ALU.
  function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic cin, input logic less);
    case (op)
      3'b000:  return {1'b0, a & b};
      3'b001:  return {1'b0, a | b};
      3'b010:  return {1'b0, a} + {1'b0, b} + {32'd0, cin};
      3'b011:  return {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
      3'b111:  return {1'b0, 31'd0, less};
      default: return 33'd0;
    endcase
  endfunction

  // Expected {err, carry, result} for a request.
  function automatic logic [33:0] exp_fn(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input bit sgn);
    logic [32:0] s;
    logic        lt;
    case (f)
      3'b000: return {2'b00, a & b};
      3'b001: return {2'b00, a | b};
      3'b010: begin s = {1'b0, a} + {1'b0, b};          return {1'b0, s}; end
      3'b011: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; return {1'b0, s}; end
      3'b111: begin
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        return {2'b00, 31'd0, lt};
      end
      default: return {1'b1, 1'b0, 32'd0};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_issue_ctrl #(.SLT_SIGNED(g == 0)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready[g]),
      .req_func      (req_func),
      .req_a         (req_a),
      .req_b         (req_b),
      .rsp_valid     (rsp_valid[g]),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result[g]),
      .rsp_carry     (rsp_carry[g]),
      .rsp_err       (rsp_err[g]),
`ifdef ALU_ISSUE_FLAGS_EN
      .rsp_zero      (rsp_zero[g]),
      .rsp_ovf       (rsp_ovf[g]),
`endif
      .alu_a         (alu_a[g]),
      .alu_b         (alu_b[g]),
      .alu_op        (alu_op[g]),
      .alu_carry_in  (alu_carry_in[g]),
      .alu_less      (alu_less[g]),
      .alu_result    (alu_result[g]),
      .alu_carry_out (alu_carry_out[g])
    );
    assign {alu_carry_out[g], alu_result[g]} =
      alu_fn(alu_a[g], alu_b[g], alu_op[g], alu_carry_in[g], alu_less[g]);
  end

  task automatic chk(input string tag, input int g, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d]: observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    exp_t        x;
    logic [33:0] e;
    logic [33:0] held [2];
    int          lat, n;
    bit          got;
    bit          legal;
    legal = (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b011) || (f == 3'b111);
    lat   = !legal ? 1 : ((f == 3'b111) ? 3 : 2);
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk("req_ready_idle", g, req_ready[g], 1'b1);
    req_valid = 1'b1; req_func = f; req_a = a; req_b = b;
    x.e0 = exp_fn(f, a, b, 1'b1);
    x.e1 = exp_fn(f, a, b, 1'b0);
    sb.push_back(x);
    got = 1'b0;
    for (n = 1; n <= 8; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      for (int g = 0; g < 2; g++) begin
        e = (g == 0) ? x.e0 : x.e1;
        if (n == 1 && legal) begin
          chk("exec_alu_a", g, alu_a[g], a);
          chk("exec_alu_b", g, alu_b[g], b);
          chk("exec_alu_op", g, alu_op[g], (f == 3'b111) ? 3'b011 : f);
          chk("exec_cin", g, alu_carry_in[g], (f == 3'b011) || (f == 3'b111));
          chk("exec_less", g, alu_less[g], 1'b0);
        end
        if (n == 1 && !legal) begin
          chk("illegal_alu_op", g, alu_op[g], 3'b000);
          chk("illegal_alu_a", g, alu_a[g], 32'd0);
        end
        if (n == 2 && f == 3'b111) begin
          chk("slt2_alu_op", g, alu_op[g], 3'b111);
          chk("slt2_less", g, alu_less[g], e[0]);
          chk("slt2_cin", g, alu_carry_in[g], 1'b0);
        end
      end
      if (rsp_valid[0] || rsp_valid[1]) begin got = 1'b1; break; end
    end
    for (int g = 0; g < 2; g++) chk("latency", g, got ? rsp_valid[g] * n : 0, lat);
    if (!got) begin
      sb.delete();
      return;
    end
    for (int g = 0; g < 2; g++) held[g] = {rsp_err[g], rsp_carry[g], rsp_result[g]};
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin req_valid = 1'b1; req_func = 3'b001; req_a = ~a; req_b = ~b; end
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk("hold_valid", g, rsp_valid[g], 1'b1);
        chk("hold_req_ready", g, req_ready[g], 1'b0);
        chk("hold_stable", g, {rsp_err[g], rsp_carry[g], rsp_result[g]}, held[g]);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    x = sb.pop_front();
    for (int g = 0; g < 2; g++) begin
      e = (g == 0) ? x.e0 : x.e1;
      chk("rsp", g, {rsp_err[g], rsp_carry[g], rsp_result[g]}, e);
`ifdef ALU_ISSUE_FLAGS_EN
      chk("rsp_zero", g, rsp_zero[g], e[31:0] == 32'd0);
`endif
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("post_rsp_valid", g, rsp_valid[g], 1'b0);
      chk("post_req_ready", g, req_ready[g], 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] rf;
    reset_n = 1'b0; req_valid = 1'b0; req_func = 3'b000;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("reset_rsp_valid", g, rsp_valid[g], 1'b0);
      chk("reset_req_ready", g, req_ready[g], 1'b1);
      chk("reset_rsp", g, {rsp_err[g], rsp_carry[g], rsp_result[g]}, 34'd0);
      chk("reset_alu", g, {alu_a[g], alu_b[g], alu_op[g], alu_carry_in[g], alu_less[g]}, 69'd0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    issue(3'b010, 32'h7FFF0000, 32'h0000FFFF, 0);
    issue(3'b011, 32'h00000000, 32'hFFFFFFFF, 0);
    issue(3'b111, 32'hFFFFFFFF, 32'h00000001, 0);
    issue(3'b101, 32'h12345678, 32'h9ABCDEF0, 0);
    issue(3'b000, 32'hA5A5F00F, 32'h0FF0FFFF, 5);
    issue(3'b001, 32'h00F000F0, 32'h0F000F00, 0);
    issue(3'b111, 32'h00000001, 32'hFFFFFFFF, 0);
    issue(3'b111, 32'h80000000, 32'h7FFFFFFF, 0);
    issue(3'b111, 32'h00000005, 32'h00000005, 0);
    issue(3'b010, 32'hFFFFFFFF, 32'h00000001, 0);
    issue(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 3);
    issue(3'b110, 32'h1, 32'h2, 0);
    issue(3'b011, 32'h80000000, 32'h00000001, 2);

    // Reset while the SLT request sits in its second ALU pass.
    @(negedge clk);
    req_valid = 1'b1; req_func = 3'b111; req_a = 32'hFFFFFFFF; req_b = 32'h00000001;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk("pre_reset_slt2_op", g, alu_op[g], 3'b111);
    #2 reset_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("midreset_rsp_valid", g, rsp_valid[g], 1'b0);
      chk("midreset_rsp", g, {rsp_err[g], rsp_carry[g], rsp_result[g]}, 34'd0);
      chk("midreset_alu", g, {alu_a[g], alu_b[g], alu_op[g], alu_carry_in[g], alu_less[g]}, 69'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) chk("no_rsp_after_reset", g, rsp_valid[g], 1'b0);
    end
    rsp_ready = 1'b0;
    issue(3'b010, 32'h00000010, 32'h00000020, 0);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 5))
        0: rf = 3'b000;
        1: rf = 3'b001;
        2: rf = 3'b010;
        3: rf = 3'b011;
        4: rf = 3'b111;
        default: rf = 3'b100;
      endcase
      issue(rf, $urandom, $urandom, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
